// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: ALU function codes
// and the scheduler FSM state type.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_MUL  = 3'd2;
  localparam logic [2:0] ALU_XOR  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_XNOR = 3'd6;
  localparam logic [2:0] ALU_NAND = 3'd7;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping past N-1. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler that shares one ALU among N_REQ requesters, one
// operation at a time, with a watchdog that turns a silent ALU into an error.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int W       = 8,
  parameter int TIMEOUT = 16,
  localparam int IW     = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_op1,
  input  logic [N_REQ*W-1:0] req_op2,
  input  logic [N_REQ*3-1:0] req_fn,
  output logic               alu_enable,
  output logic [2:0]         alu_fn,
  output logic [W-1:0]       alu_op1,
  output logic [W-1:0]       alu_op2,
  input  logic [2*W-1:0]     alu_out,
  input  logic               alu_valid,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*W-1:0]     rsp_data,
  output logic [IW-1:0]      rsp_id,
  output logic               rsp_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            alu_enable_q, alu_enable_d;
  logic [2:0]      alu_fn_q, alu_fn_d;
  logic [W-1:0]    alu_op1_q, alu_op1_d;
  logic [W-1:0]    alu_op2_q, alu_op2_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [2*W-1:0]  rsp_data_q, rsp_data_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic            rsp_err_q, rsp_err_d;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready  = (state_q == IDLE) ? gnt : '0;
  assign alu_enable = alu_enable_q;
  assign alu_fn     = alu_fn_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;

  // The ALU operands double as the holding registers; enable is raised on the
  // grant edge so it is high for exactly the ISSUE cycle.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    alu_enable_d = 1'b0;
    alu_fn_d     = alu_fn_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d      = ISSUE;
          id_d         = gnt_idx;
          alu_enable_d = 1'b1;
          alu_fn_d     = req_fn[gnt_idx*3 +: 3];
          alu_op1_d    = req_op1[gnt_idx*W +: W];
          alu_op2_d    = req_op2[gnt_idx*W +: W];
          ptr_d        = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // A result arriving on the last allowed cycle still beats the watchdog.
        if (alu_valid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_out;
          rsp_err_d   = 1'b0;
          rsp_id_d    = id_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = id_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      alu_enable_q <= 1'b0;
      alu_fn_q     <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      alu_enable_q <= alu_enable_d;
      alu_fn_q     <= alu_fn_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched: a vector table of single-requester
// operations plus hand-written arbitration, back-pressure, timeout and reset sequences.
module tb_alu_rr_sched;
  import alu_pkg::*;

  localparam int N_REQ   = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 8;
  localparam int IW      = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_op1 = '0;
  logic [N_REQ*W-1:0] req_op2 = '0;
  logic [N_REQ*3-1:0] req_fn = '0;
  logic               alu_enable;
  logic [2:0]         alu_fn;
  logic [W-1:0]       alu_op1;
  logic [W-1:0]       alu_op2;
  logic [2*W-1:0]     alu_out;
  logic               alu_valid;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [2*W-1:0]     rsp_data;
  logic [IW-1:0]      rsp_id;
  logic               rsp_err;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  alu_rr_sched #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_fn     (req_fn),
    .alu_enable (alu_enable),
    .alu_fn     (alu_fn),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_out    (alu_out),
    .alu_valid  (alu_valid),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: alu_delay cycles after an enable, alu_valid pulses with the
  // result; a delay of 0 models an ALU that never answers.
  int          alu_delay = 1;
  int          cd = 0;
  logic [15:0] res = '0;

  function automatic logic [15:0] aluCalc(logic [2:0] fn, logic [7:0] a, logic [7:0] b);
    logic [15:0] x;
    logic [15:0] y;
    x = {8'h00, a};
    y = {8'h00, b};
    case (fn)
      ALU_ADD:  return x + y;
      ALU_SUB:  return x - y;
      ALU_MUL:  return x * y;
      ALU_XOR:  return x ^ y;
      ALU_AND:  return x & y;
      ALU_OR:   return x | y;
      ALU_XNOR: return ~(x ^ y);
      default:  return ~(x & y);
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) cd <= 0;
    else if (alu_enable && alu_delay != 0) begin
      cd  <= alu_delay;
      res <= aluCalc(alu_fn, alu_op1, alu_op2);
    end else if (cd != 0) cd <= cd - 1;
  end

  assign alu_valid = (cd == 1);
  assign alu_out   = alu_valid ? res : 16'hDEAD;

  typedef struct {
    int          id;
    logic [2:0]  fn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [2:0] fn, input logic [7:0] a, input logic [7:0] b);
    req_fn[id*3 +: 3]  = fn;
    req_op1[id*W +: W] = a;
    req_op2[id*W +: W] = b;
    req_valid[id]      = 1'b1;
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_alu_enable"}, 32'(alu_enable), 0);
    checkOutput({tag, "_alu_fn"},     32'(alu_fn), 0);
    checkOutput({tag, "_alu_op1"},    32'(alu_op1), 0);
    checkOutput({tag, "_alu_op2"},    32'(alu_op2), 0);
    checkOutput({tag, "_rsp_valid"},  32'(rsp_valid), 0);
    checkOutput({tag, "_rsp_data"},   32'(rsp_data), 0);
    checkOutput({tag, "_rsp_id"},     32'(rsp_id), 0);
    checkOutput({tag, "_rsp_err"},    32'(rsp_err), 0);
    checkOutput({tag, "_req_ready"},  32'(req_ready), 0);
  endtask

  // Waits (bounded) for a grant, checks it against exp_id, follows the
  // operation to its response and completes the handshake after 'hold' stall cycles.
  task automatic serveGrant(input int exp_id, input logic [15:0] exp_data, input logic exp_err,
                            input int exp_lat, input bit drop, input int hold, output int gcyc);
    int t;
    int g;
    #1;
    t = 0;
    while (req_ready == '0 && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    gcyc = cyc;
    checkOutput("grant", 32'(req_ready), 32'(1) << exp_id);
    g = -1;
    for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
    @(negedge clk);
    if (drop && g >= 0) req_valid[g] = 1'b0;
    checkOutput("alu_enable", 32'(alu_enable), 1);
    checkOutput("alu_fn",     32'(alu_fn),  32'(req_fn[exp_id*3 +: 3]));
    checkOutput("alu_op1",    32'(alu_op1), 32'(req_op1[exp_id*W +: W]));
    checkOutput("alu_op2",    32'(alu_op2), 32'(req_op2[exp_id*W +: W]));
    t = 1;
    while (!rsp_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    checkOutput("latency", 32'(t), 32'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      checkOutput("stall_valid", 32'(rsp_valid), 1);
      checkOutput("stall_data",  32'(rsp_data), 32'(exp_data));
      checkOutput("stall_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    checkOutput("rsp_valid", 32'(rsp_valid), 1);
    checkOutput("rsp_data",  32'(rsp_data), 32'(exp_data));
    checkOutput("rsp_id",    32'(rsp_id), 32'(exp_id));
    checkOutput("rsp_err",   32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    #1;
    checkOutput("no_grant_in_resp", 32'(req_ready), 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_drop", 32'(rsp_valid), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int gc;
    int prev;
    bit seen;

    vecs[0] = '{0, ALU_ADD,  8'd200, 8'd100, 16'h012C};
    vecs[1] = '{1, ALU_SUB,  8'd5,   8'd10,  16'hFFFB};
    vecs[2] = '{2, ALU_MUL,  8'd255, 8'd255, 16'hFE01};
    vecs[3] = '{3, ALU_XOR,  8'hF0,  8'h3C,  16'h00CC};
    vecs[4] = '{0, ALU_AND,  8'hF0,  8'h3C,  16'h0030};
    vecs[5] = '{1, ALU_OR,   8'hF0,  8'h3C,  16'h00FC};
    vecs[6] = '{2, ALU_XNOR, 8'hF0,  8'h3C,  16'hFF33};
    vecs[7] = '{3, ALU_NAND, 8'hFF,  8'h0F,  16'hFFF0};
    vecs[8] = '{0, ALU_SUB,  8'd0,   8'd1,   16'hFFFF};
    vecs[9] = '{3, ALU_MUL,  8'd16,  8'd16,  16'h0100};

    resetDut();
    #1;
    checkAllZero("reset");

    // Two requesters valid together: 0 then 1, and again 0 then 1 after wrap.
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      applyStimulus(0, ALU_SUB, 8'd5, 8'd10);
      applyStimulus(1, ALU_MUL, 8'd255, 8'd255);
      serveGrant(0, 16'hFFFB, 1'b0, 3, 1'b1, 0, gc);
      serveGrant(1, 16'hFE01, 1'b0, 3, 1'b1, 0, gc);
    end

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].id, vecs[i].fn, vecs[i].a, vecs[i].b);
      serveGrant(vecs[i].id, vecs[i].exp, 1'b0, 3, 1'b1, 0, gc);
    end

    // All four requesters held valid: grants rotate 0,1,2,3,0 at least 4 cycles apart.
    resetDut();
    for (int i = 0; i < N_REQ; i++) applyStimulus(i, ALU_ADD, 8'(i), 8'(i));
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      serveGrant(k % 4, 16'(2 * (k % 4)), 1'b0, 3, k == 4, 0, gc);
      if (k > 0) checkOutput("grant_gap_ge4", 32'(gc - prev >= 4), 1);
      prev = gc;
    end
    req_valid = '0;

    // Response back-pressure with a bystander requester waiting.
    applyStimulus(1, ALU_XOR, 8'hF0, 8'h3C);
    applyStimulus(2, ALU_ADD, 8'd3, 8'd4);
    serveGrant(1, 16'h00CC, 1'b0, 3, 1'b1, 5, gc);
    serveGrant(2, 16'h0007, 1'b0, 3, 1'b1, 0, gc);

    // Silent ALU trips the watchdog; a result on the last WAIT cycle wins.
    alu_delay = 0;
    applyStimulus(1, ALU_ADD, 8'd1, 8'd2);
    serveGrant(1, 16'h0000, 1'b1, 10, 1'b1, 0, gc);
    alu_delay = 8;
    applyStimulus(1, ALU_ADD, 8'd1, 8'd2);
    serveGrant(1, 16'h0003, 1'b0, 10, 1'b1, 0, gc);

    // Reset during WAIT aborts the operation and returns the pointer to 0.
    alu_delay = 0;
    applyStimulus(2, ALU_ADD, 8'd7, 8'd7);
    #1;
    checkOutput("abort_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAllZero("abort");
    alu_delay = 1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("aborted_no_rsp", 32'(seen), 0);
    applyStimulus(0, ALU_NAND, 8'hFF, 8'h0F);
    applyStimulus(3, ALU_ADD, 8'd1, 8'd1);
    serveGrant(0, 16'hFFF0, 1'b0, 3, 1'b1, 0, gc);
    serveGrant(3, 16'h0002, 1'b0, 3, 1'b1, 0, gc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
